it8951_host_responder: RTL

//  Device side of the IT8951 host link; the command generator drives the host side. Consumes 16-bit words from an SPI-slave deserializer.

---
 rtl/it8951_host_responder.sv | 293 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/it8951_host_responder.sv
// Device-side model of the IT8951 host link: decodes preamble/command/data frames from an
// SPI-slave deserializer, keeps the link registers, streams pixels and answers reads.
module it8951_host_responder #(
  parameter logic [15:0] PANEL_W      = 16'd1872,
  parameter logic [15:0] PANEL_H      = 16'd1404,
  parameter logic [25:0] BUF_ADDR     = 26'h0,
  parameter int          DPY_BUSY_CYC = 1000,
  parameter int          HRDY_CYC     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs_n,
  input  logic        rx_valid,
  input  logic [15:0] rx_word,
  output logic [15:0] tx_word,
  output logic        hrdy,
  output logic        sys_run,
  output logic        packed_en,
  output logic [25:0] img_base,
  output logic [15:0] vcom,
  output logic [15:0] area_x,
  output logic [15:0] area_y,
  output logic [15:0] area_w,
  output logic [15:0] area_h,
  output logic [15:0] ld_info,
  output logic        ld_active,
  output logic        pix_valid,
  output logic [15:0] pix_word,
  output logic [23:0] pix_count,
  output logic        dpy_start,
  output logic [15:0] dpy_mode,
  output logic        lut_busy,
  output logic        proto_err
);

  localparam int BW = (DPY_BUSY_CYC < 2) ? 1 : $clog2(DPY_BUSY_CYC + 1);
  localparam int HW = (HRDY_CYC < 2) ? 1 : $clog2(HRDY_CYC + 1);
  localparam logic [BW-1:0] BUSY_INIT = BW'(DPY_BUSY_CYC);
  localparam logic [HW-1:0] HRDY_INIT = HW'(HRDY_CYC);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_CMD, S_WDAT, S_RDUMMY, S_RDAT, S_DISCARD
  } state_t;

  typedef enum logic [1:0] {RK_NONE, RK_REG, RK_DEV, RK_VAL} rd_kind_t;

  // {known, arg count}
  function automatic logic [3:0] op_info(input logic [15:0] op);
    case (op)
      16'h0001: op_info = 4'b1000;
      16'h0010: op_info = 4'b1001;
      16'h0011: op_info = 4'b1010;
      16'h0302: op_info = 4'b1000;
      16'h0021: op_info = 4'b1101;
      16'h0022: op_info = 4'b1000;
      16'h0034: op_info = 4'b1101;
      16'h0039: op_info = 4'b1010;
      default:  op_info = 4'b0000;
    endcase
  endfunction

  // Firmware and LUT version strings are all zero in this model.
  function automatic logic [15:0] dev_word(input logic [4:0] idx);
    case (idx)
      5'd0:    dev_word = PANEL_W;
      5'd1:    dev_word = PANEL_H;
      5'd2:    dev_word = BUF_ADDR[15:0];
      5'd3:    dev_word = {6'b0, BUF_ADDR[25:16]};
      default: dev_word = 16'h0000;
    endcase
  endfunction

  state_t         state, state_d;
  rd_kind_t       rd_kind;
  logic           cs_q, cs_fall, cs_rise;
  logic           cmd_got;
  logic [15:0]    op_p1;
  logic [2:0]     arg_cnt, arg_idx;
  logic [15:0]    args_p0 [5];
  logic           exec_vld_p1;
  logic [HW-1:0]  hcnt;
  logic [BW-1:0]  busy_cnt;
  logic [15:0]    i80cpcr, lisar_lo, lisar_hi;
  logic [15:0]    rd_addr, rd_val, rd_word;
  logic [4:0]     rd_idx;
  logic [3:0]     op_dec;
  logic           ev_cmd_open, ev_opc, ev_arg, ev_pix, ev_rd_open, ev_rd_adv;
  logic           err_word, err_any;

  assign cs_fall   = cs_q & ~cs_n;
  assign cs_rise   = ~cs_q & cs_n;
  assign op_dec    = op_info(rx_word);
  assign hrdy      = (hcnt == '0);
  assign lut_busy  = (busy_cnt != '0);
  assign packed_en = i80cpcr[0];
  assign img_base  = {lisar_hi[9:0], lisar_lo};
  assign tx_word   = (state == S_RDUMMY || state == S_RDAT) ? rd_word : 16'h0000;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Frame decode: chip-select edges win over a word arriving in the same cycle.
  always_comb begin
    state_d     = state;
    ev_cmd_open = 1'b0;
    ev_opc      = 1'b0;
    ev_arg      = 1'b0;
    ev_pix      = 1'b0;
    ev_rd_open  = 1'b0;
    ev_rd_adv   = 1'b0;
    err_word    = 1'b0;
    if (cs_rise) begin
      state_d = S_IDLE;
    end else if (cs_fall) begin
      state_d = S_PRE;
    end else if (rx_valid) begin
      case (state)
        S_PRE: begin
          case (rx_word)
            16'h6000: begin state_d = S_CMD;    ev_cmd_open = 1'b1; end
            16'h0000: begin state_d = S_WDAT;                       end
            16'h1000: begin state_d = S_RDUMMY; ev_rd_open  = 1'b1; end
            default:  begin state_d = S_DISCARD; err_word   = 1'b1; end
          endcase
        end
        S_CMD: begin
          if (!cmd_got) ev_opc = 1'b1;
          else          err_word = 1'b1;
        end
        S_WDAT: begin
          if (arg_cnt != '0) ev_arg = 1'b1;
          else if (ld_active) ev_pix = 1'b1;
          else err_word = 1'b1;
        end
        S_RDUMMY: state_d = S_RDAT;
        S_RDAT:   ev_rd_adv = 1'b1;
        default:  ;
      endcase
    end
  end

  always_comb begin
    err_any = err_word
            | (ev_opc & ((arg_cnt != '0) | ~op_dec[3]))
            | (ev_rd_open & (rd_kind == RK_NONE))
            | (rx_valid & (hcnt != '0))
            | (exec_vld_p1 & (op_p1 == 16'h0022) & ~ld_active);
  end

  always_comb begin
    rd_word = 16'h0000;
    case (rd_kind)
      RK_REG: begin
        if (rd_idx == '0) begin
          case (rd_addr)
            16'h0004: rd_word = i80cpcr;
            16'h0208: rd_word = lisar_lo;
            16'h020A: rd_word = lisar_hi;
            16'h1224: rd_word = {15'b0, lut_busy};
            default:  rd_word = 16'h0000;
          endcase
        end
      end
      RK_DEV: rd_word = dev_word(rd_idx);
      RK_VAL: if (rd_idx == '0) rd_word = rd_val;
      default: ;
    endcase
  end

  // Stage p0: argument capture
  always_ff @(posedge clk) begin
    if (ev_arg) args_p0[arg_idx] <= rx_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q        <= 1'b0;
      cmd_got     <= 1'b0;
      op_p1       <= 16'h0000;
      arg_cnt     <= '0;
      arg_idx     <= '0;
      exec_vld_p1 <= 1'b0;
      hcnt        <= '0;
      busy_cnt    <= '0;
      i80cpcr     <= 16'h0000;
      lisar_lo    <= BUF_ADDR[15:0];
      lisar_hi    <= {6'b0, BUF_ADDR[25:16]};
      rd_kind     <= RK_NONE;
      rd_addr     <= 16'h0000;
      rd_val      <= 16'h0000;
      rd_idx      <= '0;
      sys_run     <= 1'b0;
      vcom        <= 16'h0000;
      area_x      <= 16'h0000;
      area_y      <= 16'h0000;
      area_w      <= 16'h0000;
      area_h      <= 16'h0000;
      ld_info     <= 16'h0000;
      ld_active   <= 1'b0;
      pix_valid   <= 1'b0;
      pix_word    <= 16'h0000;
      pix_count   <= 24'h0;
      dpy_start   <= 1'b0;
      dpy_mode    <= 16'h0000;
      proto_err   <= 1'b0;
    end else begin
      cs_q        <= cs_n;
      exec_vld_p1 <= 1'b0;
      pix_valid   <= 1'b0;
      dpy_start   <= 1'b0;
      proto_err   <= err_any;

      if (rx_valid)        hcnt <= HRDY_INIT;
      else if (hcnt != '0) hcnt <= hcnt - 1'b1;
      if (busy_cnt != '0)  busy_cnt <= busy_cnt - 1'b1;

      if (ev_cmd_open) cmd_got <= 1'b0;
      if (ev_opc) begin
        cmd_got     <= 1'b1;
        op_p1       <= rx_word;
        arg_idx     <= '0;
        arg_cnt     <= op_dec[2:0];
        exec_vld_p1 <= op_dec[3] & (op_dec[2:0] == 3'd0);
      end
      if (ev_arg) begin
        arg_idx <= arg_idx + 3'd1;
        arg_cnt <= arg_cnt - 3'd1;
        if (arg_cnt == 3'd1) exec_vld_p1 <= 1'b1;
      end

      if (ev_pix) begin
        pix_valid <= 1'b1;
        pix_word  <= rx_word;
        if (pix_count != 24'hFFFFFF) pix_count <= pix_count + 24'd1;
      end

      if (ev_rd_open) rd_idx <= '0;
      if (ev_rd_adv && rd_idx != 5'd31) rd_idx <= rd_idx + 5'd1;
      if (cs_rise && (state == S_RDUMMY || state == S_RDAT)) rd_kind <= RK_NONE;

      // Stage p1: command execution, one cycle after the last argument
      if (exec_vld_p1) begin
        case (op_p1)
          16'h0001: sys_run <= 1'b1;
          16'h0010: begin
            rd_addr <= args_p0[0];
            rd_kind <= RK_REG;
          end
          16'h0011: begin
            case (args_p0[0])
              16'h0004: i80cpcr  <= args_p0[1];
              16'h0208: lisar_lo <= args_p0[1];
              16'h020A: lisar_hi <= args_p0[1];
              default:  ;
            endcase
          end
          16'h0021: begin
            ld_info   <= args_p0[0];
            area_x    <= args_p0[1];
            area_y    <= args_p0[2];
            area_w    <= args_p0[3];
            area_h    <= args_p0[4];
            pix_count <= 24'h0;
            ld_active <= 1'b1;
          end
          16'h0022: ld_active <= 1'b0;
          16'h0034: begin
            area_x    <= args_p0[0];
            area_y    <= args_p0[1];
            area_w    <= args_p0[2];
            area_h    <= args_p0[3];
            dpy_mode  <= args_p0[4];
            dpy_start <= 1'b1;
            busy_cnt  <= BUSY_INIT;
          end
          16'h0039: begin
            if (args_p0[0] == 16'h0001) begin
              vcom <= args_p0[1];
            end else if (args_p0[0] == 16'h0000) begin
              rd_val  <= vcom;
              rd_kind <= RK_VAL;
            end
          end
          16'h0302: rd_kind <= RK_DEV;
          default:  ;
        endcase
      end
    end
  end

endmodule
